regf_wr_arbiter: RTL

//  Round-robin arbiter sharing the single write port of the 4x8 register file
//  (wr_e/wr_addr/wr_data) between N_REQ requesters. Supports locked bursts

---
 rtl/regf_wr_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/regf_wr_arbiter.sv
// regf_wr_arbiter
//   Round-robin arbiter for the single write port of the 4x8 register file.
//   Requesters may lock the port for consecutive beats. A locked burst is capped
//   at MAX_LOCK beats. The winning address and data are registered onto the
//   regfile write port, one cycle after the beat.
//
// Ports
//   clk       in   1        clock, rising edge
//   rst_b     in   1        asynchronous active-low reset
//   req       in   N_REQ    per-requester request, held until granted
//   lock      in   N_REQ    with req: keep ownership for the next beat
//   req_addr  in   2*N_REQ  packed addresses, requester i at [2*i+1:2*i]
//   req_data  in   8*N_REQ  packed data, requester i at [8*i+7:8*i]
//   gnt       out  N_REQ    combinational one-hot grant (req&gnt at edge = beat)
//   wr_e      out  1        registered regfile write enable
//   wr_addr   out  2        registered regfile write address
//   wr_data   out  8        registered regfile write data
//   locked    out  1        registered, high while in LOCK
//
// state | meaning
// ------+-----------------------------------------------------------------
// ARB   | round-robin scan from ptr; a locked winner moves to LOCK
// LOCK  | owner keeps the port while lock is held, up to MAX_LOCK beats
module regf_wr_arbiter #(
    parameter int N_REQ    = 3,
    parameter int MAX_LOCK = 4
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     lock,
    input  logic [2*N_REQ-1:0]   req_addr,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     gnt,
    output logic                 wr_e,
    output logic [1:0]           wr_addr,
    output logic [7:0]           wr_data,
    output logic                 locked
);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [1:0]       owner, owner_nxt;
    logic [3:0]       beat_cnt, beat_cnt_nxt;

    logic             found;
    logic [1:0]       winner;
    logic [1:0]       sel;
    logic             sel_req;
    logic             sel_lock;
    logic [1:0]       sel_addr;
    logic [7:0]       sel_data;
    logic             grant_en;
    logic [N_REQ-1:0] gnt_raw;

    function automatic logic [1:0] inc_mod(input logic [1:0] x);
        if (x == 2'(N_REQ - 1)) begin
            return 2'd0;
        end
        return x + 2'd1;
    endfunction

    // Round-robin scan: candidate order ptr, ptr+1, ... wrapping mod N_REQ.
    always_comb begin
        logic [2:0] idx;
        found  = 1'b0;
        winner = 2'd0;
        idx    = 3'd0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr} + 3'(k);
            if (idx >= 3'(N_REQ)) begin
                idx = idx - 3'(N_REQ);
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && req[i] && (idx == 3'(i))) begin
                    found  = 1'b1;
                    winner = 2'(i);
                end
            end
        end
    end

    // Mux out the selected requester's inputs with constant indices only.
    always_comb begin
        sel      = (state == ST_LOCK) ? owner : winner;
        sel_req  = 1'b0;
        sel_lock = 1'b0;
        sel_addr = 2'd0;
        sel_data = 8'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel == 2'(i)) begin
                sel_req  = req[i];
                sel_lock = lock[i];
                sel_addr = req_addr[2*i +: 2];
                sel_data = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        owner_nxt    = owner;
        beat_cnt_nxt = beat_cnt;
        grant_en     = 1'b0;
        case (state)
            ST_ARB: begin
                if (found) begin
                    grant_en = 1'b1;
                    ptr_nxt  = inc_mod(winner);
                    if (sel_lock && (MAX_LOCK > 1)) begin
                        // ptr is advanced when the burst ends, not now
                        state_nxt    = ST_LOCK;
                        owner_nxt    = winner;
                        beat_cnt_nxt = 4'd1;
                        ptr_nxt      = ptr;
                    end
                end
            end
            ST_LOCK: begin
                if (sel_req) begin
                    grant_en = 1'b1;
                    if (sel_lock && ((int'(beat_cnt) + 1) < MAX_LOCK)) begin
                        beat_cnt_nxt = beat_cnt + 4'd1;
                    end else begin
                        state_nxt = ST_ARB;
                        ptr_nxt   = inc_mod(owner);
                    end
                end else begin
                    state_nxt = ST_ARB;
                    ptr_nxt   = inc_mod(owner);
                end
            end
            default: begin
                state_nxt = ST_ARB;
            end
        endcase
    end

    always_comb begin
        gnt_raw = '0;
        for (int i = 0; i < N_REQ; i++) begin
            gnt_raw[i] = grant_en && (sel == 2'(i));
        end
    end

    // Grant is forced low during reset even though req is still live.
    assign gnt = rst_b ? gnt_raw : '0;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= ST_ARB;
            ptr      <= 2'd0;
            owner    <= 2'd0;
            beat_cnt <= 4'd0;
            locked   <= 1'b0;
            wr_e     <= 1'b0;
            wr_addr  <= 2'd0;
            wr_data  <= 8'd0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
            beat_cnt <= beat_cnt_nxt;
            locked   <= (state_nxt == ST_LOCK);
            wr_e     <= grant_en;
            if (grant_en) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end

endmodule
